// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KP_ROWS        = 4;
    localparam int KP_COLS        = 4;
    localparam int KP_VALID_BIT   = 4;
    localparam int KP_PRESSED_BIT = 5;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } kp_state_e;

    // Lowest closed column of an active-low column vector: {hit, index}.
    function automatic logic [2:0] kp_first_col(input logic [KP_COLS-1:0] col_n);
        logic [2:0] res;
        res = 3'b000;
        for (int c = KP_COLS - 1; c >= 0; c--) begin
            if (!col_n[c]) begin
                res = {1'b1, 2'(c)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer bringing the asynchronous keypad columns into i_clk.
module keypad_col_sync #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-stage capture; reset loads the all-open level so no phantom key appears.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with first-hit capture, press/release debounce and
// a sticky new-key flag for the LSU input bank.
//
// Key handshake: o_key_valid rises the cycle after a key is accepted and
// stays high until a cycle in which i_key_ack is high; the flag drops on the
// following cycle. If an acceptance and an ack fall in the same cycle the
// flag stays set. o_key_code is only ever replaced by a newer acceptance.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [KP_COLS-1:0]  i_col,
    output logic [KP_ROWS-1:0]  o_row,
    input  logic                i_key_ack,
    output logic [3:0]          o_key_code,
    output logic                o_key_valid,
    output logic                o_key_pressed,
    output logic [31:0]         o_key_word,
    output kp_state_e           o_dbg_state
);

    localparam int              SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam int              CW        = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

    logic [KP_COLS-1:0] col_s;
    logic [SW-1:0]      slot_q;
    logic [1:0]         row_q;
    logic               sample;

    logic [2:0]         col_info;
    logic               cur_hit;
    logic [3:0]         cur_code;
    logic               merged_hit;
    logic [3:0]         merged_code;

    logic               acc_hit_q;
    logic [3:0]         acc_code_q;
    logic               scan_hit_q;
    logic [3:0]         scan_code_q;
    logic               scan_done_q;

    kp_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [3:0]         cand_q, cand_d;
    logic               accept;
    logic               release_done;

    logic [3:0]         key_code_q;
    logic               key_valid_q;
    logic               key_pressed_q;

    keypad_col_sync #(.W(KP_COLS)) u_col_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_col),
        .o_q     (col_s)
    );

    assign sample = (slot_q == SLOT_LAST);
    assign o_row  = ~(4'b0001 << row_q);

    // Slot counter and row index; the row moves on when the slot wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            slot_q <= '0;
            row_q  <= 2'd0;
        end else if (sample) begin
            slot_q <= '0;
            row_q  <= row_q + 2'd1;
        end else begin
            slot_q <= slot_q + 1'b1;
        end
    end

    // Merge this row's lowest closed column with what earlier rows already found.
    always_comb begin
        col_info    = kp_first_col(col_s);
        cur_hit     = col_info[2];
        cur_code    = {row_q, col_info[1:0]};
        merged_hit  = acc_hit_q | cur_hit;
        merged_code = acc_hit_q ? acc_code_q : (cur_hit ? cur_code : 4'd0);
    end

    // Accumulate across a full scan; publish at the row-3 sample and start fresh.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc_hit_q   <= 1'b0;
            acc_code_q  <= 4'd0;
            scan_hit_q  <= 1'b0;
            scan_code_q <= 4'd0;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            if (sample) begin
                if (row_q == 2'd3) begin
                    scan_hit_q  <= merged_hit;
                    scan_code_q <= merged_code;
                    scan_done_q <= 1'b1;
                    acc_hit_q   <= 1'b0;
                    acc_code_q  <= 4'd0;
                end else begin
                    acc_hit_q   <= merged_hit;
                    acc_code_q  <= merged_code;
                end
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    assign cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

    // Debounce next-state logic; only a completed scan can move the FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cand_d       = cand_q;
        accept       = 1'b0;
        release_done = 1'b0;
        if (scan_done_q) begin
            case (state_q)
                IDLE: begin
                    if (scan_hit_q) begin
                        cand_d = scan_code_q;
                        cnt_d  = CNT_ONE;
                        if (DEBOUNCE_CNT == 1) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end else begin
                            state_d = DB_PRESS;
                        end
                    end
                end
                DB_PRESS: begin
                    if (!scan_hit_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (scan_code_q == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_MAX) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end
                    end else begin
                        cand_d = scan_code_q;
                        cnt_d  = CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!scan_hit_q) begin
                        cnt_d = CNT_ONE;
                        if (DEBOUNCE_CNT == 1) begin
                            state_d      = IDLE;
                            cnt_d        = '0;
                            release_done = 1'b1;
                        end else begin
                            state_d = DB_RELEASE;
                        end
                    end
                end
                DB_RELEASE: begin
                    if (scan_hit_q) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_MAX) begin
                            state_d      = IDLE;
                            cnt_d        = '0;
                            release_done = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Key outputs: acceptance latches the code and sets both flags; set beats ack.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            if (accept) begin
                key_code_q  <= cand_d;
                key_valid_q <= 1'b1;
            end else if (i_key_ack) begin
                key_valid_q <= 1'b0;
            end
            if (accept) begin
                key_pressed_q <= 1'b1;
            end else if (release_done) begin
                key_pressed_q <= 1'b0;
            end
        end
    end

    // Pack the LSU input-bank word.
    always_comb begin
        o_key_word                 = 32'd0;
        o_key_word[3:0]            = key_code_q;
        o_key_word[KP_VALID_BIT]   = key_valid_q;
        o_key_word[KP_PRESSED_BIT] = key_pressed_q;
    end

    assign o_key_code    = key_code_q;
    assign o_key_valid   = key_valid_q;
    assign o_key_pressed = key_pressed_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CNT=3.
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic [3:0]  i_col;
    logic [3:0]  o_row;
    logic        i_key_ack;
    logic [3:0]  o_key_code;
    logic        o_key_valid;
    logic        o_key_pressed;
    logic [31:0] o_key_word;
    kp_state_e   o_dbg_state;

    logic [15:0] keys;
    int          compared;
    int          mismatched;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_col         (i_col),
        .o_row         (o_row),
        .i_key_ack     (i_key_ack),
        .o_key_code    (o_key_code),
        .o_key_valid   (o_key_valid),
        .o_key_pressed (o_key_pressed),
        .o_key_word    (o_key_word),
        .o_dbg_state   (o_dbg_state)
    );

    // Clock and watchdog.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Keypad matrix: a closed key pulls its column low while its row is driven.
    always_comb begin
        i_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !o_row[r]) i_col[c] = 1'b0;
    end

    // Advance to the cycle in which the row wraps 3 -> 0 (scan_done cycle).
    task automatic wait_boundary();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            prev = o_row;
            @(negedge i_clk);
            if (prev == 4'b0111 && o_row == 4'b1110) found = 1'b1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL scan_boundary: got timeout expected row wrap");
        end
    endtask

    // Hold a key mask for one full scan, then step to where its result is visible.
    task automatic do_scan(input logic [15:0] mask);
        keys = mask;
        wait_boundary();
        @(negedge i_clk);
    endtask

    task automatic pulse_ack();
        i_key_ack = 1'b1;
        @(negedge i_clk);
        i_key_ack = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        keys = 16'h0000;
        i_key_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        compared++; if (o_row !== 4'b1110) begin mismatched++; $display("FAIL reset_row: got %b expected 1110", o_row); end
        compared++; if (o_key_word !== 32'h0) begin mismatched++; $display("FAIL reset_word: got %h expected 0", o_key_word); end
        compared++; if (o_key_code !== 4'h0) begin mismatched++; $display("FAIL reset_code: got %h expected 0", o_key_code); end
        compared++; if ({o_key_valid, o_key_pressed} !== 2'b00) begin mismatched++; $display("FAIL reset_flags: got %b expected 00", {o_key_valid, o_key_pressed}); end
        compared++; if (o_dbg_state !== IDLE) begin mismatched++; $display("FAIL reset_state: got %0d expected IDLE", o_dbg_state); end
    endtask

    task automatic test_row_cycle();
        logic [3:0] exp_row;
        i_rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_row = ~(4'b0001 << (k / 4));
            compared++;
            if (o_row !== exp_row) begin mismatched++; $display("FAIL row_cycle[%0d]: got %b expected %b", k, o_row, exp_row); end
            @(negedge i_clk);
        end
        compared++; if (o_key_word !== 32'h0) begin mismatched++; $display("FAIL idle_word: got %h expected 0", o_key_word); end
    endtask

    task automatic test_single_key();
        repeat (2) do_scan(16'h0200);
        compared++; if (o_key_word !== 32'h0) begin mismatched++; $display("FAIL single_pre: got %h expected 0", o_key_word); end
        do_scan(16'h0200);
        compared++; if (o_key_word !== 32'h39) begin mismatched++; $display("FAIL single_accept: got %h expected 39", o_key_word); end
        compared++; if (o_dbg_state !== PRESSED) begin mismatched++; $display("FAIL single_state: got %0d expected PRESSED", o_dbg_state); end
        do_scan(16'h0200);
        compared++; if (o_key_word !== 32'h39) begin mismatched++; $display("FAIL single_hold: got %h expected 39", o_key_word); end
        pulse_ack();
        compared++; if (o_key_word !== 32'h29) begin mismatched++; $display("FAIL single_ack: got %h expected 29", o_key_word); end
        repeat (3) do_scan(16'h0000);
        compared++; if (o_key_word !== 32'h09) begin mismatched++; $display("FAIL single_release: got %h expected 09", o_key_word); end
        compared++; if (o_dbg_state !== IDLE) begin mismatched++; $display("FAIL single_idle: got %0d expected IDLE", o_dbg_state); end
    endtask

    task automatic test_bounce();
        do_scan(16'h0001);
        do_scan(16'h0001);
        do_scan(16'h0000);
        do_scan(16'h0001);
        do_scan(16'h0001);
        compared++; if (o_key_valid !== 1'b0) begin mismatched++; $display("FAIL bounce_valid: got %b expected 0", o_key_valid); end
        compared++; if (o_dbg_state !== DB_PRESS) begin mismatched++; $display("FAIL bounce_state: got %0d expected DB_PRESS", o_dbg_state); end
        do_scan(16'h0001);
        compared++; if (o_key_word !== 32'h30) begin mismatched++; $display("FAIL bounce_accept: got %h expected 30", o_key_word); end
        repeat (3) do_scan(16'h0000);
        compared++; if (o_key_word !== 32'h10) begin mismatched++; $display("FAIL bounce_release: got %h expected 10", o_key_word); end
        pulse_ack();
        compared++; if (o_key_word !== 32'h00) begin mismatched++; $display("FAIL bounce_ack: got %h expected 00", o_key_word); end
    endtask

    task automatic test_multi_key();
        repeat (3) do_scan(16'h1080);
        compared++; if (o_key_word !== 32'h37) begin mismatched++; $display("FAIL multi_accept: got %h expected 37", o_key_word); end
        pulse_ack();
        compared++; if (o_key_word !== 32'h27) begin mismatched++; $display("FAIL multi_ack: got %h expected 27", o_key_word); end
        repeat (2) do_scan(16'h0000);
        compared++; if (o_dbg_state !== DB_RELEASE) begin mismatched++; $display("FAIL multi_dbrel: got %0d expected DB_RELEASE", o_dbg_state); end
        compared++; if (o_key_word !== 32'h27) begin mismatched++; $display("FAIL multi_dbrel_word: got %h expected 27", o_key_word); end
        do_scan(16'h1080);
        compared++; if (o_dbg_state !== PRESSED) begin mismatched++; $display("FAIL multi_repress: got %0d expected PRESSED", o_dbg_state); end
        compared++; if (o_key_word !== 32'h27) begin mismatched++; $display("FAIL multi_no_valid: got %h expected 27", o_key_word); end
        repeat (3) do_scan(16'h0000);
        compared++; if (o_key_word !== 32'h07) begin mismatched++; $display("FAIL multi_release: got %h expected 07", o_key_word); end
    endtask

    task automatic test_ack_collide();
        repeat (2) do_scan(16'h0020);
        compared++; if (o_key_valid !== 1'b0) begin mismatched++; $display("FAIL collide_pre: got %b expected 0", o_key_valid); end
        wait_boundary();
        pulse_ack();
        compared++; if (o_key_word !== 32'h35) begin mismatched++; $display("FAIL collide_set_wins: got %h expected 35", o_key_word); end
    endtask

    task automatic test_overwrite();
        repeat (3) do_scan(16'h0000);
        compared++; if (o_key_word !== 32'h15) begin mismatched++; $display("FAIL overwrite_pre: got %h expected 15", o_key_word); end
        repeat (3) do_scan(16'h4000);
        compared++; if (o_key_word !== 32'h3E) begin mismatched++; $display("FAIL overwrite_code: got %h expected 3e", o_key_word); end
    endtask

    task automatic test_reset_mid_scan();
        bit found;
        found = 1'b0;
        keys = 16'h4000;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge i_clk);
            if (o_row == 4'b1011) found = 1'b1;
        end
        compared++; if (!found) begin mismatched++; $display("FAIL midreset_row2: got timeout expected row 1011"); end
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        compared++; if (o_row !== 4'b1110) begin mismatched++; $display("FAIL midreset_row: got %b expected 1110", o_row); end
        compared++; if (o_key_word !== 32'h0) begin mismatched++; $display("FAIL midreset_word: got %h expected 0", o_key_word); end
        compared++; if (o_key_code !== 4'h0) begin mismatched++; $display("FAIL midreset_code: got %h expected 0", o_key_code); end
        compared++; if (o_dbg_state !== IDLE) begin mismatched++; $display("FAIL midreset_state: got %0d expected IDLE", o_dbg_state); end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        compared++; if (o_row !== 4'b1101) begin mismatched++; $display("FAIL midreset_restart: got %b expected 1101", o_row); end
        repeat (2) do_scan(16'h4000);
        compared++; if (o_key_valid !== 1'b0) begin mismatched++; $display("FAIL midreset_partial: got %b expected 0", o_key_valid); end
        compared++; if (o_dbg_state !== DB_PRESS) begin mismatched++; $display("FAIL midreset_dbp: got %0d expected DB_PRESS", o_dbg_state); end
        do_scan(16'h4000);
        compared++; if (o_key_word !== 32'h3E) begin mismatched++; $display("FAIL midreset_accept: got %h expected 3e", o_key_word); end
    endtask

    // Sequencer and final report.
    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_row_cycle();
        test_single_key();
        test_bounce();
        test_multi_key();
        test_ack_collide();
        test_overwrite();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000: clock cycles each row is driven (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 4: consecutive identical scans required to accept a press or release (minimum 1).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_col, input, 4 bits: keypad columns, asynchronous, active-low (0 = key closed on the driven row).
REQ-006 The block SHALL have port o_row, output, 4 bits: row drive, active-low, exactly one bit low at a time.
REQ-007 The block SHALL have port i_key_ack, input, 1 bit: one-cycle pulse from the LSU read path that clears o_key_valid.
REQ-008 The block SHALL have port o_key_code, output, 4 bits: latched key index, row*4+col.
REQ-009 The block SHALL have port o_key_valid, output, 1 bit: sticky new-key flag.
REQ-010 The block SHALL have port o_key_pressed, output, 1 bit: level flag, high while the debounced key is held.
REQ-011 The block SHALL have port o_key_word, output, 32 bits: LSU input-bank word {26'd0, pressed[5], valid[4], code[3:0]}.

Function
REQ-012 i_col SHALL pass through a 2-FF synchronizer before any use.
REQ-013 A slot counter SHALL count 0..SCAN_DIV-1 and then wrap; at each wrap the row index SHALL advance 0→1→2→3→0, and o_row SHALL equal ~(4'b1 << row).
REQ-014 Columns SHALL be sampled only in the cycle where slot == SCAN_DIV-1, which gives the row settling time.
REQ-015 Hit/code accumulation across one scan:
- The first hit (lowest row, then lowest column) SHALL be kept.
- Later hits in the same scan SHALL be ignored.
- Scan result = {hit, code}.
REQ-016 At the row-3 sample, the scan result SHALL be registered, and scan_done SHALL pulse for one cycle in the following cycle; the accumulator SHALL clear for the next scan.
REQ-017 The FSM SHALL have states IDLE, DB_PRESS, PRESSED, DB_RELEASE, and SHALL change state only in scan_done cycles.
REQ-018 IDLE: on hit → DB_PRESS, cand_code = code, cnt = 1; if DEBOUNCE_CNT == 1, go directly to PRESSED.
REQ-019 DB_PRESS:
- Hit with the same code: cnt++; when cnt reaches DEBOUNCE_CNT → PRESSED.
- Hit with a different code: restart with the new code, cnt = 1.
- No hit → IDLE.
REQ-020 On entering PRESSED:
- o_key_code = cand_code.
- o_key_valid = 1.
- o_key_pressed = 1.
- All three SHALL be visible the cycle after the accepting scan_done.
REQ-021 PRESSED: any hit, including a different code, SHALL keep the state unchanged; no hit → DB_RELEASE, cnt = 1.
REQ-022 DB_RELEASE:
- No hit: cnt++; when cnt reaches DEBOUNCE_CNT → IDLE and o_key_pressed = 0.
- Hit → PRESSED; o_key_valid SHALL NOT be re-asserted.
REQ-023 i_key_ack SHALL clear o_key_valid next cycle; if ack and a new acceptance coincide, valid SHALL stay 1 (set wins).
REQ-024 o_key_code SHALL hold its value until the next acceptance and SHALL NOT be cleared by ack or release.
REQ-025 A new acceptance while valid is still 1 SHALL overwrite o_key_code (no queue, last key wins).
REQ-026 The debounce counter SHALL saturate at DEBOUNCE_CNT and never wrap.

Reset
REQ-027 While i_rst_n is low at a clock edge, the following SHALL hold:
- slot = 0, row = 0, o_row = 4'b1110.
- Synchronizer and accumulator cleared, scan_done = 0.
- FSM = IDLE, cnt = 0.
- o_key_code = 0, o_key_valid = 0, o_key_pressed = 0, o_key_word = 0.
REQ-028 Reset asserted mid-scan or mid-debounce SHALL discard the partial scan; after release, scanning SHALL restart at row 0, slot 0.

Structure
REQ-029 Package keypad_pkg SHALL hold:
- The FSM state enum (kp_state_e).
- The key-word bit positions (KP_VALID_BIT = 4, KP_PRESSED_BIT = 5).
- KP_ROWS = KP_COLS = 4.
REQ-030 The 2-FF synchronizer SHALL be one sub-module, keypad_col_sync; all other logic SHALL be in keypad_scan_ctrl.

Verification
All scenarios use SCAN_DIV = 4 and DEBOUNCE_CNT = 3 (scan period 16 cycles).
REQ-031 Reset, then hold i_col = 4'hF → o_row cycles 1110, 1101, 1011, 0111, changing every 4 cycles; valid = 0, pressed = 0, o_key_word = 0.
REQ-032 Hold row 2 / col 1 closed (i_col = 4'b1101 while o_row = 1011) for 4 scans → valid = 1 and code = 9 after the 3rd scan_done, o_key_word = 32'h39; pulse i_key_ack → word = 32'h29.
REQ-033 Bounce: press row 0 / col 0 for 2 scans, 1 open scan, then 2 pressed scans → valid stays 0; 3 consecutive pressed scans → valid = 1, code = 0.
REQ-034 Simultaneous keys row 1 / col 3 and row 3 / col 0 held → code = 7 (the first-hit rule); release for 2 scans then re-press → no new valid; release for 3 scans → pressed = 0.
REQ-035 Assert i_key_ack in the same cycle as an acceptance → valid = 1; assert i_rst_n = 0 mid-row-2 → o_row = 1110 next cycle and all outputs are 0.
